// File: rtl/rstl_conv_window_buf_if.sv
// Bus bundle for rstl_conv_window_buf: pixel write port, window-read handshake.
// rmax exists only when RSTL_WIN_MAX_EN is defined.
interface rstl_conv_window_buf_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int CH_W   = 2
);
    logic              wen;
    logic [CH_W-1:0]   wch;
    logic [ADDR_W-1:0] wadd;
    logic [DATA_W-1:0] data_in;
    logic              frame_clr;
    logic              full;
    logic              start;
    logic [CH_W-1:0]   rch;
    logic [ADDR_W-1:0] wrow;
    logic [ADDR_W-1:0] wcol;
    logic              busy;
    logic              rvalid;
    logic              err;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] rdata3;
`ifdef RSTL_WIN_MAX_EN
    logic [DATA_W-1:0] rmax;
`endif

    modport master (
        output wen, wch, wadd, data_in, frame_clr,
        output start, rch, wrow, wcol,
        input  full, busy, rvalid, err,
        input  rdata0, rdata1, rdata2, rdata3
`ifdef RSTL_WIN_MAX_EN
        , input rmax
`endif
    );

    modport slave (
        input  wen, wch, wadd, data_in, frame_clr,
        input  start, rch, wrow, wcol,
        output full, busy, rvalid, err,
        output rdata0, rdata1, rdata2, rdata3
`ifdef RSTL_WIN_MAX_EN
        , output rmax
`endif
    );
endinterface

// File: rtl/rstl_conv_window_buf.sv
// Multi-channel conv result buffer with a 2x2 window sequencer.
// Define RSTL_WIN_MAX_EN to add the registered signed window max (rmax).
module rstl_conv_window_buf #(
    parameter int N_COL  = 26,
    parameter int N_ROW  = 26,
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int CH_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rstl_conv_window_buf_if.slave bus
);
    localparam int MAP    = N_ROW * N_COL;
    localparam int DEPTH  = N_CH * MAP;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, DONE} state_t;

    state_t state, state_nx;

    logic        [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] mem_q, s0, s1, s2;
    logic        [CH_W-1:0]   ch_q;
    logic        [ADDR_W-1:0] row_q, col_q;
    logic        [CNT_W-1:0]  cnt;
    logic        [MEM_AW-1:0] raddr, waddr;
    logic                     wr_ok, req_ok, accept, dr, dc;

    // Range checks use full-width integers so oversized coordinates cannot alias.
    assign wr_ok = bus.wen && (int'(bus.wch) < N_CH) && (int'(bus.wadd) < MAP);
    assign waddr = MEM_AW'(int'(bus.wch) * MAP + int'(bus.wadd));

    assign req_ok = (int'(bus.rch) < N_CH)
                 && (int'(bus.wrow) <= N_ROW - 2)
                 && (int'(bus.wcol) <= N_COL - 2);
    assign accept = (state == IDLE) && bus.start && req_ok;

    always_comb begin
        dr = 1'b0;
        dc = 1'b0;
        case (state)
            RD1:     dc = 1'b1;
            RD2:     dr = 1'b1;
            RD3:     begin dr = 1'b1; dc = 1'b1; end
            default: ;
        endcase
    end

    assign raddr = MEM_AW'((int'(row_q) + int'(dr)) * N_COL
                         + int'(col_q) + int'(dc)
                         + int'(ch_q) * MAP);

    // Storage is not reset; the read is read-first on a same-edge write.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[waddr] <= bus.data_in;
        mem_q <= mem[raddr];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RD0;
            RD0:     state_nx = RD1;
            RD1:     state_nx = RD2;
            RD2:     state_nx = RD3;
            RD3:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef RSTL_WIN_MAX_EN
    logic signed [DATA_W-1:0] m01, m23, mx;

    always_comb begin
        m01 = (s1 > s0) ? s1 : s0;
        m23 = (mem_q > s2) ? mem_q : s2;
        mx  = (m23 > m01) ? m23 : m01;
    end
`endif

    // Elements are staged so rdata0..3 change only together with rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            s0         <= '0;
            s1         <= '0;
            s2         <= '0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
            bus.rdata2 <= '0;
            bus.rdata3 <= '0;
`ifdef RSTL_WIN_MAX_EN
            bus.rmax   <= '0;
`endif
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nx;
            bus.rvalid <= (state == DONE);
            bus.err    <= (state == IDLE) && bus.start && !req_ok;
            if (accept) begin
                ch_q  <= bus.rch;
                row_q <= bus.wrow;
                col_q <= bus.wcol;
            end
            case (state)
                RD1: s0 <= mem_q;
                RD2: s1 <= mem_q;
                RD3: s2 <= mem_q;
                DONE: begin
                    bus.rdata0 <= s0;
                    bus.rdata1 <= s1;
                    bus.rdata2 <= s2;
                    bus.rdata3 <= mem_q;
`ifdef RSTL_WIN_MAX_EN
                    bus.rmax   <= mx;
`endif
                end
                default: ;
            endcase
            if (bus.frame_clr)
                cnt <= '0;
            else if (wr_ok && cnt != CNT_W'(DEPTH))
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.full = (cnt == CNT_W'(DEPTH));
    assign bus.busy = (state != IDLE);

endmodule
